// File: rtl/alu_status_branch_unit.sv
// alu_status_branch_unit
// Consumer side of the ALU status interface in the MIPS-lite datapath.
// It keeps the ALU Z/N/V flags in a status register and evaluates branch
// conditions against them. It also drives the PC redirect and, for link-type
// branches, the $31 link write. The control unit uses a br_req/br_ack
// handshake with this block, and busy holds it off while a branch resolves.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flag_we, z_in/n_in/v_in  ALU status capture
//   br_req, br_op         branch request (held until br_ack) and opcode
//   pc_plus4, br_target, rs_val  operands sampled with br_req
//   br_ack                one-cycle acknowledge (RESOLVE)
//   busy                  high whenever the FSM is not IDLE
//   pc_load, next_pc      one-cycle PC redirect strobe and address
//   link_we, link_addr, link_data  one-cycle $31 link write
//   status_q              registered flags {Z,N,V}
module alu_status_branch_unit #(
  parameter int WIDTH    = 32,
  parameter int LINK_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_we,
  input  logic             z_in,
  input  logic             n_in,
  input  logic             v_in,
  input  logic             br_req,
  input  logic [2:0]       br_op,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] br_target,
  input  logic [WIDTH-1:0] rs_val,
  output logic             br_ack,
  output logic             busy,
  output logic             pc_load,
  output logic [WIDTH-1:0] next_pc,
  output logic             link_we,
  output logic [4:0]       link_addr,
  output logic [WIDTH-1:0] link_data,
  output logic [2:0]       status_q
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    RESOLVE = 2'd2,
    LINK    = 2'd3
  } state_t;

  localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);

  localparam logic [2:0] OP_BLEZAL = 3'b100;
  localparam logic [2:0] OP_BRV    = 3'b110;
  localparam logic [2:0] OP_BAL    = 3'b111;

  // Branch condition on the stored flags {Z,N,V}.
  function automatic logic cond_taken(input logic [2:0] op, input logic [2:0] flags);
    logic z;
    logic n;
    logic v;
    logic r;
    z = flags[2];
    n = flags[1];
    v = flags[0];
    case (op)
      3'b000:  r = z;
      3'b001:  r = ~z;
      3'b010:  r = n ^ v;
      3'b011:  r = z | (n ^ v);
      3'b100:  r = z | (n ^ v);
      3'b101:  r = v;
      3'b110:  r = 1'b1;
      3'b111:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [2:0]       status_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] pc4_r;
  logic [WIDTH-1:0] tgt_r;
  logic [WIDTH-1:0] rs_r;
  logic             link_pend_r;

  logic             br_ack_r;
  logic             busy_r;
  logic             pc_load_r;
  logic [WIDTH-1:0] next_pc_r;
  logic             link_we_r;
  logic [WIDTH-1:0] link_data_r;

  logic             taken_s;
  logic             links_op_s;
  logic [WIDTH-1:0] npc_s;
  logic             latch_s;
  logic             ack_s;
  logic             load_s;
  logic             link_s;
  logic             busy_s;

  // Condition and redirect target from the latched request and stored flags.
  always_comb begin
    taken_s    = cond_taken(op_r, status_r);
    links_op_s = (op_r == OP_BLEZAL) || (op_r == OP_BAL);
    if (op_r == OP_BRV) begin
      npc_s = rs_r;
    end else begin
      npc_s = tgt_r;
    end
  end

  // Next-state and strobe decode; strobes are registered one edge later so
  // they line up with the state they belong to.
  always_comb begin
    state_s = state_r;
    latch_s = 1'b0;
    ack_s   = 1'b0;
    load_s  = 1'b0;
    link_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (br_req) begin
          state_s = EVAL;
          latch_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      EVAL: begin
        // status_r here is the value before this edge, so a flag_we during
        // EVAL does not affect the decision.
        state_s = RESOLVE;
        ack_s   = 1'b1;
        load_s  = taken_s;
      end
      RESOLVE: begin
        if (link_pend_r) begin
          state_s = LINK;
          link_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LINK: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Status register; flag_we is honoured in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_r <= 3'b000;
    end else if (flag_we) begin
      status_r <= {z_in, n_in, v_in};
    end else begin
      status_r <= status_r;
    end
  end

  // Request latches, loaded when a request is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r  <= 3'b000;
      pc4_r <= '0;
      tgt_r <= '0;
      rs_r  <= '0;
    end else if (latch_s) begin
      op_r  <= br_op;
      pc4_r <= pc_plus4;
      tgt_r <= br_target;
      rs_r  <= rs_val;
    end else begin
      op_r  <= op_r;
      pc4_r <= pc4_r;
      tgt_r <= tgt_r;
      rs_r  <= rs_r;
    end
  end

  // Registered handshake, redirect and link outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_ack_r    <= 1'b0;
      busy_r      <= 1'b0;
      pc_load_r   <= 1'b0;
      link_we_r   <= 1'b0;
      link_pend_r <= 1'b0;
      next_pc_r   <= '0;
      link_data_r <= '0;
    end else begin
      br_ack_r    <= ack_s;
      busy_r      <= busy_s;
      pc_load_r   <= load_s;
      link_we_r   <= link_s;
      // Only a taken link-type branch continues from RESOLVE into LINK.
      link_pend_r <= ack_s & taken_s & links_op_s;
      if (load_s) begin
        next_pc_r <= npc_s;
      end else begin
        next_pc_r <= next_pc_r;
      end
      if (link_s) begin
        link_data_r <= pc4_r;
      end else begin
        link_data_r <= link_data_r;
      end
    end
  end

  assign br_ack    = br_ack_r;
  assign busy      = busy_r;
  assign pc_load   = pc_load_r;
  assign next_pc   = next_pc_r;
  assign link_we   = link_we_r;
  assign link_addr = LINK_ADDR;
  assign link_data = link_data_r;
  assign status_q  = status_r;

endmodule

// File: tb/tb_alu_status_branch_unit.sv
module tb_alu_status_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        flag_we;
  logic        z_in, n_in, v_in;
  logic        br_req;
  logic [2:0]  br_op;
  logic [31:0] pc_plus4, br_target, rs_val;
  logic        br_ack, busy, pc_load, link_we;
  logic [31:0] next_pc, link_data;
  logic [4:0]  link_addr;
  logic [2:0]  status_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_status_branch_unit #(.WIDTH(32), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .flag_we(flag_we),
    .z_in(z_in), .n_in(n_in), .v_in(v_in),
    .br_req(br_req), .br_op(br_op), .pc_plus4(pc_plus4),
    .br_target(br_target), .rs_val(rs_val),
    .br_ack(br_ack), .busy(busy), .pc_load(pc_load), .next_pc(next_pc),
    .link_we(link_we), .link_addr(link_addr), .link_data(link_data),
    .status_q(status_q)
  );

  typedef struct {
    logic [2:0]  flags;
    logic [2:0]  op;
    logic [31:0] pc4;
    logic [31:0] tgt;
    logic [31:0] rs;
    logic        taken;
    logic [31:0] npc;
    logic        link;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [31:0] npc;
    logic        link;
    logic [31:0] ldata;
    logic [2:0]  st;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic taken, input logic [31:0] npc, input logic link,
                          input logic [31:0] ldata, input logic [2:0] st);
    exp_t e;
    e.taken = taken; e.npc = npc; e.link = link; e.ldata = ldata; e.st = st;
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [31:0] pc4,
                           input logic [31:0] tgt, input logic [31:0] rs);
    br_req = 1'b1; br_op = op; pc_plus4 = pc4; br_target = tgt; rs_val = rs;
  endtask

  // Wait (bounded) for br_ack, compare against the scoreboard head, then
  // follow through the LINK cycle if expected and confirm return to IDLE.
  task automatic wait_ack(input int exp_lat);
    int   cyc;
    bit   seen;
    exp_t e;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (br_ack === 1'b1) seen = 1'b1;
    end
    check32("ack_seen", {31'd0, seen}, 32'd1);
    br_req = 1'b0;
    if (seen) begin
      check32("ack_latency", cyc, exp_lat);
      if (sb.size() == 0) begin
        check32("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check32("pc_load", {31'd0, pc_load}, {31'd0, e.taken});
        if (e.taken) check32("next_pc", next_pc, e.npc);
        check32("status_q", {29'd0, status_q}, {29'd0, e.st});
        check32("busy_resolve", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check32("ack_one_cycle", {31'd0, br_ack}, 32'd0);
        check32("pc_load_one_cycle", {31'd0, pc_load}, 32'd0);
        check32("link_we", {31'd0, link_we}, {31'd0, e.link});
        if (e.link) begin
          check32("link_data", link_data, e.ldata);
          check32("link_addr", {27'd0, link_addr}, 32'd31);
          @(negedge clk);
          check32("link_we_one_cycle", {31'd0, link_we}, 32'd0);
        end
        check32("busy_idle", {31'd0, busy}, 32'd0);
      end
    end
  endtask

  task automatic store_flags(input logic [2:0] f);
    @(negedge clk);
    flag_we = 1'b1; {z_in, n_in, v_in} = f;
    @(negedge clk);
    flag_we = 1'b0;
  endtask

  exp_t ec;

  initial begin
    reset = 1'b1; flag_we = 1'b0; z_in = 1'b0; n_in = 1'b0; v_in = 1'b0;
    br_req = 1'b0; br_op = 3'b000; pc_plus4 = 32'd0; br_target = 32'd0; rs_val = 32'd0;

    //            flags   op      pc4            tgt            rs             tk    npc            link
    vecs[0]  = '{3'b100, 3'b000, 32'h0040_0004, 32'h0040_0020, 32'h0000_0000, 1'b1, 32'h0040_0020, 1'b0};
    vecs[1]  = '{3'b000, 3'b000, 32'h0040_0008, 32'h0040_0020, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[2]  = '{3'b000, 3'b001, 32'h0040_000C, 32'h0040_0040, 32'h0000_0000, 1'b1, 32'h0040_0040, 1'b0};
    vecs[3]  = '{3'b001, 3'b010, 32'h0040_0010, 32'h0040_0060, 32'h0000_0000, 1'b1, 32'h0040_0060, 1'b0};
    vecs[4]  = '{3'b011, 3'b010, 32'h0040_0014, 32'h0040_0060, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[5]  = '{3'b010, 3'b011, 32'h0040_0018, 32'h0040_0080, 32'h0000_0000, 1'b1, 32'h0040_0080, 1'b0};
    vecs[6]  = '{3'b000, 3'b011, 32'h0040_001C, 32'h0040_0080, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[7]  = '{3'b100, 3'b100, 32'h0040_0104, 32'h0040_0200, 32'h0000_0000, 1'b1, 32'h0040_0200, 1'b1};
    vecs[8]  = '{3'b000, 3'b100, 32'h0040_0108, 32'h0040_0200, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[9]  = '{3'b001, 3'b101, 32'h0040_0110, 32'h0040_0300, 32'h0000_0000, 1'b1, 32'h0040_0300, 1'b0};
    vecs[10] = '{3'b110, 3'b101, 32'h0040_0114, 32'h0040_0300, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[11] = '{3'b010, 3'b110, 32'h0040_0118, 32'h0040_0900, 32'h0040_0800, 1'b1, 32'h0040_0800, 1'b0};
    vecs[12] = '{3'b000, 3'b111, 32'hFFFF_FFFC, 32'h0000_0010, 32'h1234_5678, 1'b1, 32'h0000_0010, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check32("rst_status_q", {29'd0, status_q}, 32'd0);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_br_ack", {31'd0, br_ack}, 32'd0);
    check32("rst_pc_load", {31'd0, pc_load}, 32'd0);
    check32("rst_link_we", {31'd0, link_we}, 32'd0);
    check32("rst_next_pc", next_pc, 32'd0);
    check32("rst_link_data", link_data, 32'd0);
    check32("rst_link_addr", {27'd0, link_addr}, 32'd31);
    reset = 1'b0;

    // Table-driven branches
    for (int i = 0; i < 13; i++) begin
      store_flags(vecs[i].flags);
      drive_req(vecs[i].op, vecs[i].pc4, vecs[i].tgt, vecs[i].rs);
      push_exp(vecs[i].taken, vecs[i].npc, vecs[i].link, vecs[i].pc4, vecs[i].flags);
      wait_ack(2);
    end

    // flag_we in the same cycle as br_req: new flags are used
    store_flags(3'b000);
    @(negedge clk);
    flag_we = 1'b1; {z_in, n_in, v_in} = 3'b100;
    drive_req(3'b000, 32'h0040_0A04, 32'h0040_0A00, 32'h0);
    push_exp(1'b1, 32'h0040_0A00, 1'b0, 32'h0, 3'b100);
    @(negedge clk);
    flag_we = 1'b0;
    wait_ack(1);

    // flag_we during EVAL: decision uses the flags stored before it
    store_flags(3'b100);
    drive_req(3'b000, 32'h0040_0B04, 32'h0040_0B00, 32'h0);
    push_exp(1'b1, 32'h0040_0B00, 1'b0, 32'h0, 3'b001);
    @(negedge clk);
    flag_we = 1'b1; {z_in, n_in, v_in} = 3'b001;
    wait_ack(1);
    flag_we = 1'b0;

    // New request raised during LINK is ignored until IDLE
    store_flags(3'b000);
    drive_req(3'b111, 32'h0040_0C04, 32'h0040_0C40, 32'h0);
    repeat (2) @(negedge clk);
    check32("bal_ack", {31'd0, br_ack}, 32'd1);
    check32("bal_pc_load", {31'd0, pc_load}, 32'd1);
    check32("bal_next_pc", next_pc, 32'h0040_0C40);
    br_req = 1'b0;
    @(negedge clk);
    check32("bal_link_we", {31'd0, link_we}, 32'd1);
    check32("bal_link_data", link_data, 32'h0040_0C04);
    drive_req(3'b001, 32'h0040_0D04, 32'h0040_0D00, 32'h0);
    push_exp(1'b1, 32'h0040_0D00, 1'b0, 32'h0, 3'b000);
    @(negedge clk);
    check32("busy_req_ignored", {31'd0, busy}, 32'd0);
    check32("no_ack_in_idle", {31'd0, br_ack}, 32'd0);
    wait_ack(2);

    // Reset mid-EVAL aborts the branch
    store_flags(3'b100);
    drive_req(3'b000, 32'h0040_0E04, 32'h0040_0E00, 32'h0);
    @(negedge clk);
    check32("eval_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; br_req = 1'b0;
    @(negedge clk);
    check32("abort_busy", {31'd0, busy}, 32'd0);
    check32("abort_br_ack", {31'd0, br_ack}, 32'd0);
    check32("abort_pc_load", {31'd0, pc_load}, 32'd0);
    check32("abort_link_we", {31'd0, link_we}, 32'd0);
    check32("abort_status_q", {29'd0, status_q}, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check32("abort_no_late_ack", {31'd0, br_ack}, 32'd0);
      check32("abort_no_late_load", {31'd0, pc_load}, 32'd0);
    end

    check32("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_status_branch_unit.md
Name: alu_status_branch_unit

Overview:
- Consumer side of the ALU status interface in the MIPS-lite datapath.
- Registers the ALU Z/N/V status outputs into a status register and evaluates branch conditions against the stored flags.
- Sequences the redirect and, for link-type branches, the $31 link write back to the PC and register-file write logic.
- Uses a req/ack handshake with the control unit; holds the control unit off (busy) while a branch resolves.

Parameters:
- WIDTH, 32, datapath width of PC, target and link values
- LINK_REG, 31, register index driven on link_addr

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- flag_we  input  1  latch z_in/n_in/v_in into the status register this edge
- z_in  input  1  ALU zero status
- n_in  input  1  ALU negative status (sum[31])
- v_in  input  1  ALU overflow status
- br_req  input  1  branch request; held high until br_ack
- br_op  input  3  branch opcode, sampled with br_req
- pc_plus4  input  WIDTH  PC+4 of the branch instruction, sampled with br_req
- br_target  input  WIDTH  PC-relative target, sampled with br_req
- rs_val  input  WIDTH  register target for brv, sampled with br_req
- br_ack  output  1  one-cycle acknowledge, in RESOLVE
- busy  output  1  high in every state except IDLE
- pc_load  output  1  one-cycle strobe: load next_pc into PC
- next_pc  output  WIDTH  redirect address, valid while pc_load=1
- link_we  output  1  one-cycle register-file write strobe
- link_addr  output  5  constant LINK_REG
- link_data  output  WIDTH  latched pc_plus4, valid while link_we=1
- status_q  output  3  registered flags {Z,N,V}

Behaviour:
- Reset, synchronous:
  - status_q=3'b000; state=IDLE.
  - br_ack, busy, pc_load and link_we are all 0.
  - next_pc, link_data and the request latches are 0.
  - Reset mid-operation aborts at the next edge with no pc_load or link_we.
- Status register:
  - On flag_we, status_q <= {z_in,n_in,v_in}; otherwise hold.
  - flag_we is honoured in every state.
- Condition codes, evaluated on status_q (Z,N,V):
  - 000 BZ: Z
  - 001 BNZ: ~Z
  - 010 BLTZ: N^V
  - 011 BLEZ: Z|(N^V)
  - 100 BLEZAL: Z|(N^V), links
  - 101 BVS: V
  - 110 BRV: always taken, target = rs_val
  - 111 BAL: always taken, links
- FSM states: IDLE, EVAL, RESOLVE, LINK.
  - IDLE: on br_req, latch br_op/pc_plus4/br_target/rs_val, go to EVAL.
  - EVAL: 1-cycle flag-settle slot so a same-edge flag_we is visible. Compute taken from status_q at the end of EVAL; go to RESOLVE.
  - RESOLVE: br_ack=1 for one cycle.
    - If taken: pc_load=1, next_pc = (op==110) ? rs_val_l : br_target_l.
    - If not taken: pc_load=0 (PC advances normally).
    - Go to LINK if taken and op is BLEZAL or BAL; otherwise go to IDLE.
  - LINK: link_we=1, link_data=pc_plus4_l, then go to IDLE.
  - Non-taken BLEZAL does not link (no LINK state).
- Latency:
  - br_req to br_ack/pc_load: 2 cycles.
  - Link write: 3 cycles after br_req.
  - Back-to-back requests: next accepted in the cycle after returning to IDLE.
- Handshake:
  - br_req must stay high until br_ack.
  - br_req is ignored while busy=1.
  - br_req held after br_ack is treated as a new request only once the FSM is back in IDLE; the control unit must drop it in the cycle after br_ack.
- Simultaneous events:
  - flag_we in the same cycle as br_req: the new flags are used.
  - flag_we during EVAL: evaluation uses status_q before that edge.
- Width: next_pc is taken verbatim from the latched targets; no arithmetic and no wrap logic. pc_plus4 = 0xFFFFFFFC+4 wrapping is the PC adder's responsibility.

Test Plan:
- Reset: assert reset with FSM mid-EVAL -> next cycle state IDLE, status_q=000, no pc_load or link_we, busy=0.
- BZ: flag_we with z=1, then br_req op=000, target=0x00400020 -> 2 cycles later br_ack=1, pc_load=1, next_pc=0x00400020. Repeat with z=0 -> br_ack=1, pc_load=0.
- BLTZ overflow: flags N=0, V=1 -> taken. Flags N=1, V=1 -> not taken.
- BLEZAL: flags Z=1, pc_plus4=0x00400104 -> pc_load in RESOLVE, then link_we=1, link_addr=31, link_data=0x00400104 the following cycle. With N=V=Z=0 -> no pc_load, no link_we, back to IDLE after RESOLVE.
- BRV: rs_val=0x00400800, flags arbitrary -> next_pc=0x00400800, no link.
- Simultaneous/handshake:
  - flag_we z=1 in the same cycle as br_req BZ -> taken.
  - flag_we z=0 during EVAL after z=1 was stored -> still taken; status_q=0xx afterwards.
  - Second br_req while busy -> ignored until IDLE.
